systolic_ctrl: RTL and testbench

Sequencing controller for the weight-stationary systolic array of `PE` tiles. For each tile job it performs three steps in order: loads an N×N weight tile row by row from the weight buffer, streams `num_vec` activation vectors from the activation buffer with stall support, and generates result-buffer write strobes aligned to the array's fixed output latency. It sits between the top-level job scheduler (start/done) and the array plus its three SRAM buffers.

---
 rtl/systolic_ctrl.sv | 174 +++++++++++++++++
 tb/tb_systolic_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight-tile load, activation streaming and result write-back for one tile job.
// Latency: first buffer strobe one cycle after start; each result write lands ARRAY_LAT+1 cycles after its activation read.
// Backpressure: act_stall seen in STREAM holds the vector index and skips the next issue; the bubble propagates to pe_valid and res_wr_en.
module systolic_ctrl #(
    parameter int N         = 16,
    parameter int M_W       = 16,
    parameter int ADDR_W    = 16,
    parameter int ARRAY_LAT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reuse_wt,
    input  logic [M_W-1:0]    num_vec,
    input  logic [ADDR_W-1:0] wt_base,
    input  logic [ADDR_W-1:0] act_base,
    input  logic [ADDR_W-1:0] res_base,
    input  logic              act_stall,
    output logic              busy,
    output logic              done,
    output logic              wt_rd_en,
    output logic [ADDR_W-1:0] wt_rd_addr,
    output logic [N-1:0]      wt_row_en,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              pe_valid,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr
);
    localparam int R_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [M_W-1:0]       nv_q, k_q, k_nx, j_q, j_nx;
    logic [ADDR_W-1:0]    act_base_q, wt_addr_nx, act_addr_nx;
    logic [R_W-1:0]       r_q, r_nx;
    logic                 wt_issue, act_issue, ld_job;
    logic [ARRAY_LAT-1:0] lat_pipe;

    // The oldest stage of the latency pipeline is the result write strobe.
    assign res_wr_en = lat_pipe[ARRAY_LAT-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the strobes for the coming cycle, so every output can be registered
    // and still appear one cycle after the decision (r_q/k_q index the row/vector issued now).
    always_comb begin
        state_nx    = state;
        wt_issue    = 1'b0;
        act_issue   = 1'b0;
        ld_job      = 1'b0;
        r_nx        = r_q;
        k_nx        = k_q;
        wt_addr_nx  = wt_rd_addr;
        act_addr_nx = act_rd_addr;
        j_nx        = j_q + M_W'(res_wr_en);
        case (state)
            IDLE: begin
                if (start) begin
                    ld_job = 1'b1;
                    r_nx   = '0;
                    k_nx   = '0;
                    if (!reuse_wt) begin
                        state_nx   = LOAD_W;
                        wt_issue   = 1'b1;
                        wt_addr_nx = wt_base;
                    end else if (num_vec == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx    = STREAM;
                        act_issue   = 1'b1;
                        act_addr_nx = act_base;
                        k_nx        = M_W'(1);
                    end
                end
            end
            LOAD_W: begin
                if (r_q != R_W'(N - 1)) begin
                    wt_issue   = 1'b1;
                    wt_addr_nx = wt_rd_addr + 1'b1;
                    r_nx       = r_q + 1'b1;
                end else if (nv_q == '0) begin
                    state_nx = DONE;
                end else begin
                    // First vector follows the last weight row without a gap.
                    state_nx    = STREAM;
                    act_issue   = 1'b1;
                    act_addr_nx = act_base_q;
                    k_nx        = M_W'(1);
                end
            end
            STREAM: begin
                if (k_q == nv_q) begin
                    state_nx = DRAIN;
                end else if (!act_stall) begin
                    act_issue   = 1'b1;
                    act_addr_nx = act_rd_addr + 1'b1;
                    k_nx        = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (j_nx == nv_q) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Registered outputs, job context, counters and the array-latency pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wt_rd_en    <= 1'b0;
            wt_rd_addr  <= '0;
            wt_row_en   <= '0;
            act_rd_en   <= 1'b0;
            act_rd_addr <= '0;
            pe_valid    <= 1'b0;
            res_wr_addr <= '0;
            lat_pipe    <= '0;
            nv_q        <= '0;
            act_base_q  <= '0;
            r_q         <= '0;
            k_q         <= '0;
            j_q         <= '0;
        end else begin
            busy        <= (state_nx != IDLE);
            done        <= (state_nx == DONE);
            wt_rd_en    <= wt_issue;
            wt_rd_addr  <= wt_addr_nx;
            // Row enable trails the read by one cycle to line up with returning weight data.
            wt_row_en   <= (state == LOAD_W) ? (N'(1) << r_q) : '0;
            act_rd_en   <= act_issue;
            act_rd_addr <= act_addr_nx;
            pe_valid    <= act_rd_en;
            lat_pipe    <= (lat_pipe << 1) | ARRAY_LAT'(pe_valid);
            r_q         <= r_nx;
            k_q         <= k_nx;
            if (ld_job) begin
                nv_q        <= num_vec;
                act_base_q  <= act_base;
                res_wr_addr <= res_base;
                j_q         <= '0;
            end else begin
                // Address advances only on real writes, so bubbles never skew it.
                res_wr_addr <= res_wr_addr + ADDR_W'(res_wr_en);
                j_q         <= j_nx;
            end
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed jobs against a per-cycle expectation table built from the timing rules.
// Latency: checks every output on every falling edge once reset has been applied.
// Backpressure: stall windows are part of each job's stimulus and of its expected timeline.
module tb_systolic_ctrl;
    localparam int N     = 4;
    localparam int LAT   = 7;
    localparam int JOB   = 30;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst, start, reuse_wt, act_stall;
    logic [15:0] num_vec, wt_base, act_base, res_base;
    logic        busy, done, wt_rd_en, act_rd_en, pe_valid, res_wr_en;
    logic [15:0] wt_rd_addr, act_rd_addr, res_wr_addr;
    logic [N-1:0] wt_row_en;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    int e_busy[DEPTH], e_done[DEPTH], e_wt_en[DEPTH], e_wt_addr[DEPTH], e_row[DEPTH];
    int e_act_en[DEPTH], e_act_addr[DEPTH], e_pe[DEPTH], e_res_en[DEPTH], e_res_addr[DEPTH];

    int wq[$];
    int done_off, n_wr;

    systolic_ctrl #(.N(N), .M_W(16), .ADDR_W(16), .ARRAY_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_wt(reuse_wt), .num_vec(num_vec),
        .wt_base(wt_base), .act_base(act_base), .res_base(res_base), .act_stall(act_stall),
        .busy(busy), .done(done), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .wt_row_en(wt_row_en), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
        .pe_valid(pe_valid), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected timeline of one job: weight rows, then vectors (each later vector waits for a
    // stall-free cycle after the previous issue), results LAT+1 after each read, done after the last.
    task automatic build(input int t0, input int reuse, input int nv, input int wtb, input int actb,
                         input int resb, input int slo, input int shi, input int rst_off);
        int s, c, last, d;
        for (int i = t0; i < t0 + JOB; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_wt_en[i] = 0; e_wt_addr[i] = 0; e_row[i] = 0;
            e_act_en[i] = 0; e_act_addr[i] = 0; e_pe[i] = 0; e_res_en[i] = 0; e_res_addr[i] = 0;
        end
        s = t0;
        if (reuse == 0) begin
            for (int r = 0; r < N; r++) begin
                e_wt_en[t0 + 1 + r]   = 1;
                e_wt_addr[t0 + 1 + r] = (wtb + r) & 16'hFFFF;
                e_row[t0 + 2 + r]     = 1 << r;
            end
            s = t0 + N;
        end
        if (nv == 0) begin
            d = s + 1;
        end else begin
            c = s + 1;
            last = c;
            for (int k = 0; k < nv; k++) begin
                if (k > 0) begin
                    c = c + 1;
                    while ((c - 1 - t0) >= slo && (c - 1 - t0) <= shi) c = c + 1;
                end
                e_act_en[c]              = 1;
                e_act_addr[c]            = (actb + k) & 16'hFFFF;
                e_pe[c + 1]              = 1;
                e_res_en[c + 1 + LAT]    = 1;
                e_res_addr[c + 1 + LAT]  = (resb + k) & 16'hFFFF;
                last = c + 1 + LAT;
            end
            d = last + 1;
        end
        e_done[d] = 1;
        for (int i = t0 + 1; i <= d; i++) e_busy[i] = 1;
        if (rst_off >= 0) begin
            for (int i = t0 + rst_off + 1; i < t0 + JOB; i++) begin
                e_busy[i] = 0; e_done[i] = 0; e_wt_en[i] = 0; e_row[i] = 0;
                e_act_en[i] = 0; e_pe[i] = 0; e_res_en[i] = 0;
            end
        end
    endtask

    // Per-cycle comparison of every output against the expected timeline.
    always @(negedge clk) begin
        if (chk_on && cyc < DEPTH) begin
            chk("busy", int'(busy), e_busy[cyc]);
            chk("done", int'(done), e_done[cyc]);
            chk("wt_rd_en", int'(wt_rd_en), e_wt_en[cyc]);
            chk("wt_row_en", int'(wt_row_en), e_row[cyc]);
            chk("act_rd_en", int'(act_rd_en), e_act_en[cyc]);
            chk("pe_valid", int'(pe_valid), e_pe[cyc]);
            chk("res_wr_en", int'(res_wr_en), e_res_en[cyc]);
            if (e_wt_en[cyc] != 0) chk("wt_rd_addr", int'(wt_rd_addr), e_wt_addr[cyc]);
            if (e_act_en[cyc] != 0) chk("act_rd_addr", int'(act_rd_addr), e_act_addr[cyc]);
            if (e_res_en[cyc] != 0) chk("res_wr_addr", int'(res_wr_addr), e_res_addr[cyc]);
        end
    end

    // Drive one job for JOB cycles; inputs other than start carry junk after cycle 0 to prove latching.
    task automatic job(input int reuse, input int nv, input int wtb, input int actb, input int resb,
                       input int slo, input int shi, input int rst_off, input int xstart_off,
                       input int exp_done, input int exp_wr, input string nm);
        int t0;
        t0 = cyc;
        build(t0, reuse, nv, wtb, actb, resb, slo, shi, rst_off);
        done_off = -1;
        n_wr = 0;
        wq.delete();
        for (int off = 0; off < JOB; off++) begin
            start     = (off == 0) || (off == xstart_off);
            reuse_wt  = (off == 0) ? reuse[0] : 1'b1;
            num_vec   = (off == 0) ? 16'(nv) : 16'd9;
            wt_base   = (off == 0) ? 16'(wtb) : 16'hA5A5;
            act_base  = (off == 0) ? 16'(actb) : 16'h5A5A;
            res_base  = (off == 0) ? 16'(resb) : 16'h1234;
            act_stall = (off >= slo) && (off <= shi);
            rst       = (off == rst_off);
            if (done && done_off < 0) done_off = off;
            if (res_wr_en) begin
                n_wr++;
                wq.push_back(int'(res_wr_addr));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        act_stall = 1'b0;
        rst = 1'b0;
        chk({nm, "_done_cycle"}, done_off, exp_done);
        chk({nm, "_writes"}, n_wr, exp_wr);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reuse_wt = 1'b0; act_stall = 1'b0;
        num_vec = '0; wt_base = '0; act_base = '0; res_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_res_wr_addr", int'(res_wr_addr), 0);
        chk("reset_wt_row_en", int'(wt_row_en), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: weights 0x10.., reads 5-7, writes 13-15, done 16.
        job(0, 3, 'h10, 'h20, 'h30, -1, -1, -1, -1, 16, 3, "nominal");
        // Stall on cycles 6-7: reads 5,6,9, writes 13,14,17 with contiguous addresses, done 18.
        job(0, 3, 'h10, 'h20, 'h30, 6, 7, -1, -1, 18, 3, "stall");
        chk("stall_addr0", wq.size() > 0 ? wq[0] : -1, 'h30);
        chk("stall_addr2", wq.size() > 2 ? wq[2] : -1, 'h32);
        // Resident weights: reads 1-2, writes 9-10, done follows at 11.
        job(1, 2, 'h40, 'h50, 'h60, -1, -1, -1, -1, 11, 2, "reuse");
        // Empty jobs: load only (done after the fourth row) and immediate done.
        job(0, 0, 'h70, 0, 0, -1, -1, -1, -1, 5, 0, "empty_load");
        job(1, 0, 0, 0, 0, -1, -1, -1, -1, 1, 0, "empty_reuse");
        // Reset during streaming: outputs clear, no done, no writes.
        job(0, 3, 'h10, 'h20, 'h30, -1, -1, 6, -1, -1, 0, "abort");
        // Fresh job after the abort.
        job(0, 3, 'h100, 'h200, 'h300, -1, -1, -1, -1, 16, 3, "after_abort");
        // Extra start while busy is ignored; result addresses wrap.
        job(0, 3, 'h10, 'h20, 'hFFFE, -1, -1, -1, 3, 16, 3, "wrap");
        chk("wrap_addr0", wq.size() > 0 ? wq[0] : -1, 'hFFFE);
        chk("wrap_addr1", wq.size() > 1 ? wq[1] : -1, 'hFFFF);
        chk("wrap_addr2", wq.size() > 2 ? wq[2] : -1, 'h0000);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
